// File: rtl/mic_capture_ctrl.sv
// PDM decimator capture sequencer: enable gating, warm-up discard, programmable
// sub-sampling and a register FIFO with first-word fall-through and sticky overflow.
module mic_capture_ctrl #(
  parameter int unsigned SAMPLE_DEPTH   = 16,
  parameter int unsigned FIFO_DEPTH     = 16,
  parameter int unsigned WARMUP_SAMPLES = 2048,
  parameter int unsigned DECIM_WIDTH    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [DECIM_WIDTH-1:0]        decim,
  input  logic                          in_strobe,
  input  logic signed [SAMPLE_DEPTH-1:0] in_sample,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [SAMPLE_DEPTH-1:0] out_sample,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  input  logic                          clear_ovf,
  output logic [1:0]                    state
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W  = PTR_W + 1;
  localparam int unsigned WCNT_W = $clog2(WARMUP_SAMPLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WARMUP = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t                   r_state;
  logic [WCNT_W-1:0]        r_wcnt;
  logic [DECIM_WIDTH-1:0]   r_decim_q;
  logic [DECIM_WIDTH-1:0]   r_dcnt;
  logic [SAMPLE_DEPTH-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]         r_wr_ptr;
  logic [PTR_W-1:0]         r_rd_ptr;
  logic [LVL_W-1:0]         r_level;
  logic                     r_overflow;

  logic w_start;
  logic w_push_req;
  logic w_full;
  logic w_push;
  logic w_pop;

  // A capture start flushes the FIFO, so it overrides any pop in that cycle.
  assign w_start    = (r_state == IDLE) && enable;
  assign w_push_req = (r_state == RUN) && enable && in_strobe && (r_dcnt == '0);
  assign w_full     = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push     = w_push_req && !w_full;
  assign w_pop      = out_valid && out_ready && !w_start;

  assign out_valid  = (r_level != '0);
  assign out_sample = out_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level = r_level;
  assign overflow   = r_overflow;
  assign state      = r_state;

  // Sequencer: warm-up counting and decimation counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_wcnt    <= '0;
      r_decim_q <= '0;
      r_dcnt    <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state   <= WARMUP;
            r_wcnt    <= '0;
            r_decim_q <= decim;
            r_dcnt    <= '0;
          end
        end
        WARMUP: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (in_strobe) begin
            r_wcnt <= r_wcnt + WCNT_W'(1);
            if (r_wcnt == WCNT_W'(WARMUP_SAMPLES - 1)) begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            r_state <= IDLE;
          end else if (in_strobe) begin
            if (r_dcnt == '0) begin
              r_dcnt <= r_decim_q;
            end else begin
              r_dcnt <= r_dcnt - DECIM_WIDTH'(1);
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and sticky overflow (set wins over clear).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else if (w_start) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_level    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_level <= r_level + LVL_W'(w_push) - LVL_W'(w_pop);
      if (w_push_req && w_full) begin
        r_overflow <= 1'b1;
      end else if (clear_ovf) begin
        r_overflow <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= in_sample;
    end
  end

endmodule

// File: tb/tb_mic_capture_ctrl.sv
// Directed bench for mic_capture_ctrl with a 4-entry FIFO and 4-sample warm-up.
module tb_mic_capture_ctrl;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [7:0]        decim;
  logic              in_strobe;
  logic signed [15:0] in_sample;
  logic              out_valid;
  logic              out_ready;
  logic signed [15:0] out_sample;
  logic [2:0]        fifo_level;
  logic              overflow;
  logic              clear_ovf;
  logic [1:0]        state;

  int total = 0;
  int bad   = 0;

  mic_capture_ctrl #(
    .SAMPLE_DEPTH  (16),
    .FIFO_DEPTH    (4),
    .WARMUP_SAMPLES(4),
    .DECIM_WIDTH   (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .decim     (decim),
    .in_strobe (in_strobe),
    .in_sample (in_sample),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sample(out_sample),
    .fifo_level(fifo_level),
    .overflow  (overflow),
    .clear_ovf (clear_ovf),
    .state     (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic [7:0] dec;
    logic       stb;
    logic [15:0] smp;
    logic       rdy;
    logic       clr;
    int         e_st;
    int         e_lvl;
    int         e_ovf;
    int         e_head;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input int st, input int lvl, input int ovf, input int head);
    chk({nm, ".state"},  32'(state), 32'(st));
    chk({nm, ".level"},  32'(fifo_level), 32'(lvl));
    chk({nm, ".valid"},  32'(out_valid), 32'(lvl != 0));
    chk({nm, ".sample"}, 32'(unsigned'(out_sample)), 32'(head));
    chk({nm, ".ovf"},    32'(overflow), 32'(ovf));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic en, input logic [7:0] dc, input logic stb,
                      input logic [15:0] smp, input logic rdy, input logic clr);
    enable    = en;
    decim     = dc;
    in_strobe = stb;
    in_sample = smp;
    out_ready = rdy;
    clear_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic en, input logic [7:0] dec, input logic stb,
                              input logic [15:0] smp, input logic rdy, input logic clr,
                              input int st, input int lvl, input int ovf, input int head);
    vec_t v;
    v.en = en; v.dec = dec; v.stb = stb; v.smp = smp; v.rdy = rdy; v.clr = clr;
    v.e_st = st; v.e_lvl = lvl; v.e_ovf = ovf; v.e_head = head;
    return v;
  endfunction

  initial begin
    // Warm-up then decim=2 (latched); decim changed to 0 mid-RUN must not matter.
    vecs[0]  = mk(1, 2, 0, 0,  0, 0, 1, 0, 0, 0);
    vecs[1]  = mk(1, 2, 1, 1,  0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1, 2, 1, 2,  0, 0, 1, 0, 0, 0);
    vecs[3]  = mk(1, 2, 1, 3,  0, 0, 1, 0, 0, 0);
    vecs[4]  = mk(1, 2, 1, 4,  0, 0, 2, 0, 0, 0);
    vecs[5]  = mk(1, 2, 1, 5,  0, 0, 2, 1, 0, 5);
    vecs[6]  = mk(1, 0, 1, 6,  0, 0, 2, 1, 0, 5);
    vecs[7]  = mk(1, 0, 1, 7,  0, 0, 2, 1, 0, 5);
    vecs[8]  = mk(1, 0, 1, 8,  0, 0, 2, 2, 0, 5);
    vecs[9]  = mk(1, 0, 0, 0,  1, 0, 2, 1, 0, 8);
    vecs[10] = mk(1, 0, 1, 9,  1, 0, 2, 0, 0, 0);
    vecs[11] = mk(0, 0, 1, 10, 0, 0, 0, 0, 0, 0);

    rst = 1'b1; enable = 0; decim = 0; in_strobe = 0; in_sample = 0;
    out_ready = 0; clear_ovf = 0;
    #12;
    chk_all("por", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    step(0, 0, 0, 0, 0, 0);
    chk_all("idle", 0, 0, 0, 0);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].en, vecs[i].dec, vecs[i].stb, vecs[i].smp, vecs[i].rdy, vecs[i].clr);
      chk_all($sformatf("vec%0d", i), vecs[i].e_st, vecs[i].e_lvl, vecs[i].e_ovf, vecs[i].e_head);
    end

    // Overflow: decim=0, strobes 1..11 with no reads; only 5..8 fit.
    step(1, 0, 0, 0, 0, 0);
    for (int s = 1; s <= 11; s++) step(1, 0, 1, 16'(s), 0, 0);
    chk_all("ovf_full", 2, 4, 1, 5);
    step(1, 0, 1, 12, 1, 0);
    chk_all("ovf_pop_while_full", 2, 3, 1, 6);
    step(1, 0, 1, 13, 0, 0);
    chk_all("ovf_refill", 2, 4, 1, 6);
    step(1, 0, 1, 14, 0, 1);
    chk_all("ovf_set_wins", 2, 4, 1, 6);
    step(1, 0, 0, 0, 0, 1);
    chk_all("ovf_clear", 2, 4, 0, 6);
    step(1, 0, 0, 0, 1, 0);
    chk_all("drain0", 2, 3, 0, 7);
    step(1, 0, 0, 0, 1, 0);
    chk_all("drain1", 2, 2, 0, 8);
    step(1, 0, 0, 0, 1, 0);
    chk_all("drain2", 2, 1, 0, 13);
    step(1, 0, 0, 0, 1, 0);
    chk_all("drain3", 2, 0, 0, 0);

    // Streaming: push and pop every cycle keeps occupancy at one.
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 16'(100 + i), 1, 0);
      chk_all($sformatf("stream%0d", i), 2, 1, 0, 100 + i);
    end
    step(1, 0, 0, 0, 1, 0);
    chk_all("stream_end", 2, 0, 0, 0);

    // Restart: drop enable with 3 queued, drain one, re-enable with 2 queued.
    step(1, 0, 1, 200, 0, 0);
    step(1, 0, 1, 201, 0, 0);
    step(1, 0, 1, 202, 0, 0);
    chk_all("rs_queued", 2, 3, 0, 200);
    step(0, 0, 1, 203, 0, 0);
    chk_all("rs_idle", 0, 3, 0, 200);
    step(0, 0, 0, 0, 1, 0);
    chk_all("rs_idle_pop", 0, 2, 0, 201);
    step(1, 0, 0, 0, 1, 0);
    chk_all("rs_flush", 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 1, 16'(250 + i), 0, 0);
      chk_all($sformatf("rs_warm%0d", i), 1, 0, 0, 0);
    end
    step(1, 0, 1, 253, 0, 0);
    chk_all("rs_run", 2, 0, 0, 0);
    step(1, 0, 1, 300, 0, 0);
    chk_all("rs_first_push", 2, 1, 0, 300);

    // Asynchronous reset mid-RUN with 3 queued, no clock edge in between.
    step(1, 0, 1, 301, 0, 0);
    step(1, 0, 1, 302, 0, 0);
    chk_all("rst_pre", 2, 3, 0, 300);
    #2;
    rst = 1'b1;
    #1;
    chk_all("rst_async", 0, 0, 0, 0);
    enable = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 16'(400 + i), 1, 0);
      chk_all($sformatf("rst_after%0d", i), 0, 0, 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
